// File: rtl/matrix_renderer.sv
// Row-scanned driver for the 8x16 LED matrix: latches one game-state snapshot per
// frame, blanks the start of each row slot, blinks bonus coins and shows the score at game over.
module matrix_renderer #(
   parameter int SCAN_DIV     = 1000,
   parameter int BLANK        = 4,
   parameter int BLINK_FRAMES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  player_x,
   input  logic [2:0]  coin_x,
   input  logic [3:0]  coin_y,
   input  logic        coin_type,
   input  logic [7:0]  score,
   input  logic        time_up,
   output logic [15:0] row,
   output logic [7:0]  col,
   output logic        frame_start
);

   localparam int DIV_W   = $clog2(SCAN_DIV);
   localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [DIV_W-1:0]   div;
   logic [3:0]         row_idx;
   logic [FRAME_W-1:0] frame_cnt;
   logic               blink_on;

   logic [2:0] snap_player_x;
   logic [2:0] snap_coin_x;
   logic [3:0] snap_coin_y;
   logic       snap_coin_type;
   logic [7:0] snap_score;
   logic       snap_time_up;

   logic       slot_tick;
   logic [7:0] pattern;

   assign slot_tick = (div == DIV_W'(SCAN_DIV - 1));

   // Inputs are only captured on the last cycle of row 15 so a whole frame
   // is drawn from one coherent game state.
   always_ff @(posedge clk) begin
      if (reset) begin
         div            <= '0;
         row_idx        <= '0;
         frame_cnt      <= '0;
         blink_on       <= 1'b1;
         frame_start    <= 1'b0;
         snap_player_x  <= '0;
         snap_coin_x    <= '0;
         snap_coin_y    <= '0;
         snap_coin_type <= 1'b0;
         snap_score     <= '0;
         snap_time_up   <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         if (slot_tick) begin
            div     <= '0;
            row_idx <= row_idx + 4'd1;
            if (row_idx == 4'd15) begin
               snap_player_x  <= player_x;
               snap_coin_x    <= coin_x;
               snap_coin_y    <= coin_y;
               snap_coin_type <= coin_type;
               snap_score     <= score;
               snap_time_up   <= time_up;
               frame_start    <= 1'b1;
               if (frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
                  frame_cnt <= '0;
                  blink_on  <= ~blink_on;
               end else begin
                  frame_cnt <= frame_cnt + FRAME_W'(1);
               end
            end
         end else begin
            div <= div + DIV_W'(1);
         end
      end
   end

   // Row pattern is a pure function of registered state; player and coin
   // share a column bit when they overlap so only one LED lights.
   always_comb begin
      pattern = '0;
      if (snap_time_up) begin
         if (row_idx == 4'd0)
            pattern = snap_score;
      end else begin
         if (row_idx == 4'd15)
            pattern[snap_player_x] = 1'b1;
         if ((row_idx == snap_coin_y) && (!snap_coin_type || blink_on))
            pattern[snap_coin_x] = 1'b1;
      end
   end

   always_comb begin
      row = 16'd1 << row_idx;
      col = (div < DIV_W'(BLANK)) ? 8'h00 : pattern;
   end

endmodule

// File: tb/tb_matrix_renderer.sv
// Directed bench for matrix_renderer with SCAN_DIV=8, BLANK=2, BLINK_FRAMES=2
// (one row slot = 8 cycles, one frame = 128 cycles).
module tb_matrix_renderer;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  player_x;
   logic [2:0]  coin_x;
   logic [3:0]  coin_y;
   logic        coin_type;
   logic [7:0]  score;
   logic        time_up;
   logic [15:0] row;
   logic [7:0]  col;
   logic        frame_start;

   int check_count = 0;
   int fail_count  = 0;
   int cyc         = 0;

   matrix_renderer #(
      .SCAN_DIV    (8),
      .BLANK       (2),
      .BLINK_FRAMES(2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .player_x   (player_x),
      .coin_x     (coin_x),
      .coin_y     (coin_y),
      .coin_type  (coin_type),
      .score      (score),
      .time_up    (time_up),
      .row        (row),
      .col        (col),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s (cycle %0d): got 0x%0h, want 0x%0h", tag, cyc, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] px, input logic [2:0] cx, input logic [3:0] cy,
                                input logic ct, input logic [7:0] sc, input logic tu);
      player_x  = px;
      coin_x    = cx;
      coin_y    = cy;
      coin_type = ct;
      score     = sc;
      time_up   = tu;
   endtask

   // Cycle n is the period following the n-th edge after reset release; we sample 2ns into it.
   task automatic goToCycle(input int n);
      while (cyc < n) begin
         @(posedge clk);
         cyc++;
         #2;
      end
   endtask

   task automatic checkCol(input int n, input string tag, input logic [7:0] want);
      goToCycle(n);
      checkOutput(tag, 32'(col), 32'(want));
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      applyStimulus(3'd0, 3'd0, 4'd0, 1'b0, 8'h00, 1'b0);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      checkOutput("fs_in_reset", 32'(frame_start), 32'h0);
      reset = 1'b0;
      cyc   = 0;

      // Frame 1 setup: steady coin at (5,7), player at column 3
      applyStimulus(3'd3, 3'd5, 4'd7, 1'b0, 8'h00, 1'b0);

      // Frame 0 shows the reset snapshot
      goToCycle(0);
      checkOutput("rst_row_c0", 32'(row), 32'h0001);
      checkOutput("rst_col_c0", 32'(col), 32'h00);
      checkOutput("rst_fs_c0", 32'(frame_start), 32'h0);
      checkCol(1, "rst_col_c1", 8'h00);
      checkCol(2, "rst_col_c2", 8'h01);
      checkCol(7, "rst_col_c7", 8'h01);
      goToCycle(8);
      checkOutput("rst_row_c8", 32'(row), 32'h0002);
      checkOutput("rst_col_c8", 32'(col), 32'h00);
      checkCol(10, "rst_row1_col", 8'h00);
      goToCycle(122);
      checkOutput("rst_row_c122", 32'(row), 32'h8000);
      checkOutput("rst_col_c122", 32'(col), 32'h01);
      goToCycle(127);
      checkOutput("rst_col_c127", 32'(col), 32'h01);
      checkOutput("fs_c127", 32'(frame_start), 32'h0);
      goToCycle(128);
      checkOutput("fs_c128", 32'(frame_start), 32'h1);
      checkOutput("f1_row_c128", 32'(row), 32'h0001);
      goToCycle(129);
      checkOutput("fs_c129", 32'(frame_start), 32'h0);

      // Frame 1: steady coin
      checkCol(130, "steady_row0", 8'h00);
      checkCol(178, "steady_row6", 8'h00);
      checkCol(184, "steady_blank184", 8'h00);
      checkCol(185, "steady_blank185", 8'h00);
      goToCycle(186);
      checkOutput("steady_row7_sel", 32'(row), 32'h0080);
      checkOutput("steady_row7_c186", 32'(col), 32'h20);
      // Mid-frame change must not tear the frame being drawn
      applyStimulus(3'd3, 3'd2, 4'd7, 1'b0, 8'h00, 1'b0);
      checkCol(191, "tear_row7_c191", 8'h20);
      checkCol(194, "steady_row8", 8'h00);
      checkCol(250, "steady_row15", 8'h08);

      // Frame 2: new coin column becomes visible
      goToCycle(256);
      checkOutput("fs_c256", 32'(frame_start), 32'h1);
      checkCol(314, "tear_f2_row7", 8'h04);
      checkCol(378, "f2_row15", 8'h08);
      applyStimulus(3'd4, 3'd4, 4'd15, 1'b0, 8'h00, 1'b0);

      // Frame 3: player and coin overlap on row 15 (normal coin visible in a dark blink phase)
      checkCol(442, "overlap_row7", 8'h00);
      checkCol(386, "overlap_row0", 8'h00);
      checkCol(498, "overlap_row14", 8'h00);
      checkCol(506, "overlap_row15", 8'h10);
      applyStimulus(3'd0, 3'd5, 4'd7, 1'b1, 8'h00, 1'b0);

      // Frames 4..8: bonus coin blinks with a two-frame half period
      checkCol(570, "blink_f4", 8'h20);
      checkCol(698, "blink_f5", 8'h20);
      checkCol(826, "blink_f6", 8'h00);
      checkCol(890, "blink_f6_player", 8'h01);
      checkCol(954, "blink_f7", 8'h00);
      checkCol(1082, "blink_f8", 8'h20);
      applyStimulus(3'd0, 3'd5, 4'd7, 1'b1, 8'hA5, 1'b1);

      // Frame 9: score screen
      goToCycle(1152);
      checkOutput("fs_c1152", 32'(frame_start), 32'h1);
      checkCol(1153, "score_blank", 8'h00);
      checkCol(1154, "score_row0_c1154", 8'hA5);
      checkCol(1159, "score_row0_c1159", 8'hA5);
      checkCol(1210, "score_row7", 8'h00);
      checkCol(1274, "score_row15", 8'h00);

      // Mid-frame reset
      goToCycle(1300);
      reset = 1'b1;
      @(posedge clk);
      #2;
      checkOutput("mrst_row", 32'(row), 32'h0001);
      checkOutput("mrst_col", 32'(col), 32'h00);
      checkOutput("mrst_fs", 32'(frame_start), 32'h0);
      reset = 1'b0;
      cyc   = 0;
      checkCol(2, "mrst_snap_row0", 8'h01);
      checkCol(122, "mrst_snap_row15", 8'h01);
      goToCycle(127);
      checkOutput("mrst_fs_c127", 32'(frame_start), 32'h0);
      goToCycle(128);
      checkOutput("mrst_fs_c128", 32'(frame_start), 32'h1);
      checkCol(130, "mrst_f1_score", 8'hA5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", check_count, fail_count);
      $finish;
   end

endmodule

// File: doc/matrix_renderer.md
# matrix_renderer

Scans the 8-column × 16-row LED dot matrix from the game state produced by the game core: player position, coin position/type, score and time-up. It latches one consistent snapshot per frame to avoid tearing, drives one row at a time with a short blanking gap, and blinks bonus coins. When time is up it shows the score on the matrix. It sits between the game core outputs and the matrix pins, on the fast display clock.

## Interface

- SCAN_DIV, 1000, clk cycles per row slot (≥ 2)
- BLANK, 4, cycles at the start of each row slot with col forced to 0 (1 ≤ BLANK < SCAN_DIV)
- BLINK_FRAMES, 16, frames per half-period of the bonus-coin blink (≥ 1)

- clk  in  1  display clock; one clock domain
- reset  in  1  synchronous, active-high
- player_x  in  3  player column, 0–7; player always on row 15
- coin_x  in  3  coin column, 0–7
- coin_y  in  4  coin row, 0–15
- coin_type  in  1  0 = normal coin (steady), 1 = bonus coin (blinking)
- score  in  8  current score
- time_up  in  1  1 = game over, score screen
- row  out  16  one-hot row select, active-high; bit i = row i
- col  out  8  column drive, active-high; bit j = column j
- frame_start  out  1  one-cycle pulse in the first cycle of row 0 of each new frame

## Operation

- State: div counter (0..SCAN_DIV-1), row_idx (0..15), snapshot regs (player_x, coin_x, coin_y, coin_type, score, time_up), frame_cnt (0..BLINK_FRAMES-1), blink_on, frame_start reg.
- Reset values: div=0, row_idx=0, all snapshot fields 0, frame_cnt=0, blink_on=1, frame_start=0. Outputs after reset: row=16'h0001, col=8'h00, frame_start=0.
- Slot tick is the cycle with div==SCAN_DIV-1. On the next edge div wraps to 0 and row_idx increments, wrapping 15→0. Otherwise div increments.
- Frame edge is a slot tick with row_idx==15. On that edge:
  - Snapshot loads all inputs.
  - frame_start is set to 1 for exactly one cycle.
  - If frame_cnt==BLINK_FRAMES-1: frame_cnt←0 and blink_on toggles. Otherwise frame_cnt increments.
- Inputs are sampled only at frame edges. Input changes mid-frame have no visible effect until the next frame.
- row = one-hot(row_idx) at all times.
- col = 0 while div < BLANK. Otherwise it takes the pattern for row_idx from the snapshot:
  - When snap time_up=0:
    - Bit snap player_x is set if row_idx==15.
    - Bit snap coin_x is set if row_idx==snap coin_y and (snap coin_type==0 or blink_on).
    - The two are OR'd. When player and coin coincide, one bit is lit.
  - When snap time_up=1: row 0 shows col=snap score, rows 1–15 show col=0. Player and coin are hidden.
- row and col depend only on registered state; there is no input-to-output combinational path.
- Reset asserted mid-frame returns everything to the reset values on the next edge. The first frame after reset displays the reset snapshot: coin at (0,0) normal, player at column 0.

## Timing

- Row slot = SCAN_DIV cycles, of which BLANK cycles are dark. Frame = 16·SCAN_DIV cycles.
- Cycle 0 is the first cycle with reset low.
- frame_start is high in cycles 16·SCAN_DIV·k for k ≥ 1, and never during or immediately after reset.
- Input-to-display latency: input values present at cycle 16·SCAN_DIV·k − 1 are shown during frame k (cycles 16·SCAN_DIV·k onward).
- Blink: frames numbered from 0 after reset. The coin is visible in frames where ⌊frame/BLINK_FRAMES⌋ is even, and dark otherwise.

## Test plan

All scenarios use SCAN_DIV=8, BLANK=2, BLINK_FRAMES=2.

- Reset behaviour: hold reset 3 cycles, then release. Required response:
  - row=0x0001, col=0x00 in cycles 0–1; col=0x01 in cycles 2–7.
  - row=0x8000, col=0x01 in cycles 122–127.
  - frame_start first high at cycle 128 only.
- Steady coin: player_x=3, coin_x=5, coin_y=7, coin_type=0, static. Required response in frame 1:
  - Row 7 slot (cycles 184–191): col=0x00 in 184–185, 0x20 in 186–191.
  - Row 15: col=0x08.
  - All other rows: col=0x00.
- Overlap: player_x=4, coin_x=4, coin_y=15. Required response: row 15 shows col=0x10; all other rows show 0x00.
- Blinking bonus coin: coin_type=1, coin_x=5, coin_y=7. Required response: row 7 shows 0x20 in frames 0–1 and 4–5, and 0x00 in frames 2–3 and 6–7.
- No tearing: change coin_x from 5 to 2 at cycle 200 (mid-frame 1). Required response: frame 1 still shows 0x20 on row 7; frame 2 (from cycle 256) shows 0x04.
- Score screen and mid-frame reset:
  - Set time_up=1, score=0xA5 before cycle 255. Frame 2 row 0 shows col=0xA5 (cycles 258–263); all other rows show 0x00.
  - Assert reset at cycle 300. Next cycle shows row=0x0001, col=0x00, frame_start=0.
